// File: rtl/nash_pkg.sv
// Shared types and default widths for the Nash cipher serializer/deserializer pair.
package nash_pkg;

  localparam int unsigned NASH_DATA_WIDTH     = 8;
  localparam int unsigned NASH_SER_FIFO_DEPTH = 4;

  typedef enum logic [0:0] {
    SER_IDLE  = 1'b0,
    SER_SHIFT = 1'b1
  } ser_state_e;

endpackage

// File: rtl/nash_byte_fifo.sv
// Synchronous FIFO with occupancy counter; flush has priority over push and pop.
module nash_byte_fifo
  import nash_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = NASH_DATA_WIDTH,
  parameter int unsigned DEPTH      = NASH_SER_FIFO_DEPTH
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          flush,
  input  logic                          push,
  input  logic [DATA_WIDTH-1:0]         wdata,
  input  logic                          pop,
  output logic [DATA_WIDTH-1:0]         rdata,
  output logic                          full,
  output logic                          empty,
  output logic [$clog2(DEPTH):0]        count
);

  localparam int unsigned PtrW = $clog2(DEPTH);
  localparam int unsigned CntW = PtrW + 1;

  logic [DATA_WIDTH-1:0] mem_q [DEPTH];
  logic [PtrW-1:0]       wr_ptr_q, wr_ptr_d;
  logic [PtrW-1:0]       rd_ptr_q, rd_ptr_d;
  logic [CntW-1:0]       count_q, count_d;
  logic                  do_push, do_pop;

  assign full  = (count_q == CntW'(DEPTH));
  assign empty = (count_q == '0);
  assign count = count_q;
  assign rdata = mem_q[rd_ptr_q];

  always_comb begin
    do_push  = push && !full && !flush;
    do_pop   = pop && !empty && !flush;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (do_push) wr_ptr_d = wr_ptr_q + PtrW'(1);
      if (do_pop)  rd_ptr_d = rd_ptr_q + PtrW'(1);
      unique case ({do_push, do_pop})
        2'b10:   count_d = count_q + CntW'(1);
        2'b01:   count_d = count_q - CntW'(1);
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage needs no reset: occupancy alone decides which entries are live.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= wdata;
  end

endmodule

// File: rtl/nash_byte_serializer.sv
// Buffers words and emits them MSB-first as a gapless bit stream for the Nash core.
// Optional NASH_SER_STATS_EN adds a 32-bit retired-word counter on byte_count.
module nash_byte_serializer
  import nash_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = NASH_DATA_WIDTH,
  parameter int unsigned FIFO_DEPTH = NASH_SER_FIFO_DEPTH
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [DATA_WIDTH-1:0] byte_in,
  input  logic                  byte_valid,
  output logic                  byte_ready,
  input  logic                  core_ready,
  input  logic                  abort,
  output logic                  bit_out,
  output logic                  bit_valid,
  output logic                  bit_sop,
`ifdef NASH_SER_STATS_EN
  output logic [31:0]           byte_count,
`endif
  output logic                  busy
);

  localparam int unsigned BitCntW = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;

  ser_state_e              state_q, state_d;
  logic [DATA_WIDTH-1:0]   shreg_q, shreg_d;
  logic [BitCntW-1:0]      cnt_q, cnt_d;
  logic                    valid_q, valid_d;
  logic                    sop_q, sop_d;

  logic [DATA_WIDTH-1:0]   fifo_rdata;
  logic                    fifo_full, fifo_empty;
  logic [$clog2(FIFO_DEPTH):0] fifo_count;
  logic                    last_bit, load;

  nash_byte_fifo #(
    .DATA_WIDTH (DATA_WIDTH),
    .DEPTH      (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .flush (abort),
    .push  (byte_valid),
    .wdata (byte_in),
    .pop   (load),
    .rdata (fifo_rdata),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= SER_IDLE;
      shreg_q <= '0;
      cnt_q   <= '0;
      valid_q <= 1'b0;
      sop_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      shreg_q <= shreg_d;
      cnt_q   <= cnt_d;
      valid_q <= valid_d;
      sop_q   <= sop_d;
    end
  end

  always_comb begin
    last_bit = (state_q == SER_SHIFT) && (cnt_q == '0);
    // A load can only begin at a word boundary; core_ready never cuts a word short.
    load     = !abort && !fifo_empty && core_ready &&
               ((state_q == SER_IDLE) || last_bit);
    state_d  = state_q;
    shreg_d  = shreg_q;
    cnt_d    = cnt_q;
    valid_d  = 1'b0;
    sop_d    = 1'b0;
    if (abort) begin
      state_d = SER_IDLE;
      shreg_d = '0;
      cnt_d   = '0;
    end else if (load) begin
      state_d = SER_SHIFT;
      shreg_d = fifo_rdata;
      cnt_d   = BitCntW'(DATA_WIDTH - 1);
      valid_d = 1'b1;
      sop_d   = 1'b1;
    end else begin
      unique case (state_q)
        SER_SHIFT: begin
          shreg_d = shreg_q << 1;
          if (last_bit) begin
            state_d = SER_IDLE;
            cnt_d   = '0;
          end else begin
            cnt_d   = cnt_q - BitCntW'(1);
            valid_d = 1'b1;
          end
        end
        default: begin
          state_d = SER_IDLE;
        end
      endcase
    end
  end

  always_comb begin
    bit_out    = shreg_q[DATA_WIDTH-1];
    bit_valid  = valid_q;
    bit_sop    = sop_q;
    byte_ready = !fifo_full;
    busy       = (state_q == SER_SHIFT) || (fifo_count != '0);
  end

`ifdef NASH_SER_STATS_EN
  logic [31:0] byte_count_q, byte_count_d;

  always_comb begin
    byte_count_d = byte_count_q;
    if (abort) begin
      byte_count_d = '0;
    end else if (last_bit) begin
      byte_count_d = byte_count_q + 32'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      byte_count_q <= '0;
    end else begin
      byte_count_q <= byte_count_d;
    end
  end

  assign byte_count = byte_count_q;
`endif

endmodule

// File: doc/nash_byte_serializer.md
# nash_byte_serializer

Upstream feeder for the bit-serial Nash cipher core. Accepts plaintext bytes over a valid/ready handshake, buffers them in a small FIFO, and emits them MSB-first as a continuous bit stream with a per-bit valid. Outputs drive the core's `plaintext_in`/`valid_in` directly. New bytes start only while the core reports configuration complete.

## Interface
- `DATA_WIDTH`, default 8: bits per word; shift length.
- `FIFO_DEPTH`, default 4: buffered words; power of two, ≥2.
- `clk`  in  1  single clock, rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `byte_in`  in  DATA_WIDTH  word to serialize; bit [DATA_WIDTH-1] is sent first.
- `byte_valid`  in  1  `byte_in` is valid.
- `byte_ready`  out  1  FIFO not full; a transfer occurs on `byte_valid && byte_ready` at a rising edge.
- `core_ready`  in  1  cipher core `config_ready`; gates the start of new words.
- `abort`  in  1  synchronous flush of FIFO, shifter and counters.
- `bit_out`  out  1  serial data; connects to core `plaintext_in`.
- `bit_valid`  out  1  `bit_out` is valid; connects to core `valid_in`.
- `bit_sop`  out  1  high with the first (MSB) bit of each word.
- `busy`  out  1  shifter active or FIFO non-empty.

## Operation
- States: IDLE (shifter empty), SHIFT (emitting a word).
- IDLE → SHIFT when FIFO non-empty and `core_ready`=1. The head word is popped into the shift register and the bit counter is set to DATA_WIDTH-1.
- In SHIFT, `bit_out` = shreg MSB and `bit_valid`=1. Each cycle the register shifts left and the counter decrements.
- On the last bit (counter 0):
  - If FIFO non-empty and `core_ready`=1, load the next word on the same edge. The stream is gapless.
  - Otherwise return to IDLE.
- A `core_ready` drop mid-word does not interrupt that word; it completes. It only blocks the next load.
- `bit_sop`=1 exactly in the first cycle after a load.
- FIFO: push on handshake, pop on shifter load. Simultaneous push and pop is legal at any occupancy except full, where `byte_ready`=0 so no push occurs.
- The word count must always match the real FIFO contents. Pointer wrap uses a DEPTH-sized index plus an occupancy counter of width clog2(FIFO_DEPTH)+1.
- `abort`:
  - Highest priority; any same-cycle push is dropped.
  - Next cycle: FIFO empty, state IDLE, `bit_valid`/`bit_sop`=0, `busy`=0.
- `byte_valid` must stay high with stable `byte_in` until accepted. The block does not check this.

## Timing
- Reset values: `byte_ready`=1, `bit_out`=0, `bit_valid`=0, `bit_sop`=0, `busy`=0, FIFO empty, state IDLE, counters 0.
- Latency: a word accepted at edge N into an empty, idle block with `core_ready`=1 has its MSB on `bit_out`, with `bit_valid`=`bit_sop`=1, after edge N+1. The LSB appears after edge N+DATA_WIDTH.
- `byte_ready` is combinational from the registered occupancy only. There is no path from `byte_valid`.
- `bit_out`, `bit_valid` and `bit_sop` are registered.
- `busy` is combinational from the registered state and occupancy.
- Reset asserted mid-word: all outputs go to their reset values immediately. The partial word is lost.

## Configuration
- `NASH_SER_STATS_EN` defined:
  - Adds output `byte_count` [31:0], which increments on the edge that retires the last bit of each word.
  - Wraps from 0xFFFFFFFF to 0.
  - Cleared by reset and by `abort`.
- Undefined: the port and counter are absent. All other behaviour is identical.

## Structure
- `nash_pkg` holds the state enum (`SER_IDLE`, `SER_SHIFT`) and the default widths `NASH_DATA_WIDTH`=8 and `NASH_SER_FIFO_DEPTH`=4, shared with the core-side deserializer.
- Sub-module `nash_byte_fifo` is a synchronous FIFO with push/pop/full/empty/count. The top level holds only the shifter FSM and stats.

## Test plan
- Reset, then a single push of 0xB3 → after 1 cycle `bit_out` sequence 1,0,1,1,0,0,1,1 with `bit_valid` high for exactly 8 cycles, `bit_sop` only on the first; `busy` drops the cycle after.
- Four back-to-back pushes 0xB3, 0x00, 0xFF, 0x5A → 32 contiguous `bit_valid` cycles, `bit_sop` every 8th cycle, `byte_ready` never low.
- Six pushes with no gaps → `byte_ready`=0 when occupancy reaches 4, while the shifter holds one word. All six words are emitted in order and none are lost.
- `core_ready`=0 with 2 words queued → no `bit_valid`. `core_ready` dropping mid-word → that word completes and the next waits; it starts 1 cycle after `core_ready` rises.
- `abort` on bit 3 of a word with 2 queued and a simultaneous push → next cycle `bit_valid`=0, `busy`=0, `byte_ready`=1. A later push of 0x81 emits 1,0,0,0,0,0,0,1.
- With `NASH_SER_STATS_EN`: 5 words → `byte_count`=5. `abort` → 0. Force the counter to 0xFFFFFFFF, send one word → 0.
